// File: rtl/px_stream_router.sv
// Pixel-stream router: SPI/generator sources to NUM_CH channels,
// with a flow-controlled return FIFO and idle-only mode switching.
module px_stream_router #(
    parameter int PIXEL_BITS = 24,
    parameter int NUM_CH     = 4,
    parameter int FIFO_DEPTH = 4,
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                         clk_i,
    input  logic                         reset_i,
    input  logic                         src_sel_i,
    input  logic [CH_W-1:0]              ch_sel_i,
    input  logic [PIXEL_BITS-1:0]        spi_px_i,
    input  logic                         spi_px_rdy_i,
    input  logic                         spi_busy_i,
    output logic [PIXEL_BITS-1:0]        spi_px_o,
    output logic                         spi_px_rdy_o,
    output logic [PIXEL_BITS-1:0]        gen_cfg_o,
    output logic                         gen_cfg_rdy_o,
    input  logic [PIXEL_BITS-1:0]        gen_px_i,
    input  logic                         gen_px_rdy_i,
    input  logic [PIXEL_BITS-1:0]        gen_cfg_data_i,
    input  logic                         gen_cfg_done_i,
    output logic [PIXEL_BITS-1:0]        ch_px_o,
    output logic [NUM_CH-1:0]            ch_px_rdy_o,
    input  logic [NUM_CH*PIXEL_BITS-1:0] ch_px_i,
    input  logic [NUM_CH-1:0]            ch_px_rdy_i,
    output logic                         active_src_o,
    output logic [CH_W-1:0]              active_ch_o,
    output logic                         cfg_pending_o,
    output logic [LVL_W-1:0]             fifo_level_o,
    output logic                         overflow_o
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);
    localparam logic [LVL_W-1:0] CNT_MAX  = '1;

    logic                  src_q, src_d;
    logic [CH_W-1:0]       ch_q, ch_d;
    logic                  pend_q, pend_d;
    logic [PIXEL_BITS-1:0] ch_px_q, ch_px_d;
    logic [NUM_CH-1:0]     ch_rdy_q, ch_rdy_d;
    logic [PIXEL_BITS-1:0] gcfg_q, gcfg_d;
    logic                  gcfg_rdy_q, gcfg_rdy_d;
    logic [PIXEL_BITS-1:0] spi_px_q, spi_px_d;
    logic                  spi_rdy_q, spi_rdy_d;
    logic [LVL_W-1:0]      infl_q, infl_d;
    logic [LVL_W-1:0]      lvl_q, lvl_d;
    logic [AW-1:0]         wptr_q, wptr_d;
    logic [AW-1:0]         rptr_q, rptr_d;
    logic                  ovf_q, ovf_d;
    logic [PIXEL_BITS-1:0] mem_q [FIFO_DEPTH];

    logic                  res_rdy;
    logic [PIXEL_BITS-1:0] res_px;
    logic                  idle;
    logic                  req_diff;
    logic                  req_ok;
    logic                  apply;
    logic                  fwd;
    logic [PIXEL_BITS-1:0] fwd_px;
    logic                  push;
    logic [PIXEL_BITS-1:0] push_px;
    logic                  pop;
    logic                  push_ok;
    logic                  inc;

    // Pick the active channel's result slice and pulse
    always_comb begin
        res_rdy = 1'b0;
        res_px  = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (ch_q == CH_W'(k)) begin
                res_rdy = ch_px_rdy_i[k];
                res_px  = ch_px_i[k*PIXEL_BITS +: PIXEL_BITS];
            end
        end
    end

    // Next-state: selection, forward path, in-flight count, FIFO control
    always_comb begin
        idle = (lvl_q == '0) && (infl_q == '0) && (ch_rdy_q == '0)
               && !spi_rdy_q && !gcfg_rdy_q;
        req_diff = (src_sel_i != src_q) || (ch_sel_i != ch_q);
        req_ok   = 32'(ch_sel_i) < NUM_CH;
        apply    = req_diff && req_ok && idle;

        src_d  = apply ? src_sel_i : src_q;
        ch_d   = apply ? ch_sel_i : ch_q;
        pend_d = req_diff && !apply;

        fwd    = src_q ? gen_px_rdy_i : spi_px_rdy_i;
        fwd_px = src_q ? gen_px_i : spi_px_i;
        ch_px_d = fwd ? fwd_px : ch_px_q;
        for (int k = 0; k < NUM_CH; k++) begin
            ch_rdy_d[k] = fwd && (ch_q == CH_W'(k));
        end

        gcfg_rdy_d = src_q && spi_px_rdy_i;
        gcfg_d     = gcfg_rdy_d ? spi_px_i : gcfg_q;

        inc    = ch_rdy_q != '0;
        infl_d = infl_q;
        if (inc && !res_rdy && infl_q != CNT_MAX) begin
            infl_d = infl_q + LVL_W'(1);
        end else if (res_rdy && !inc && infl_q != '0) begin
            infl_d = infl_q - LVL_W'(1);
        end

        push    = src_q ? gen_cfg_done_i : res_rdy;
        push_px = src_q ? gen_cfg_data_i : res_px;
        pop     = (lvl_q != '0) && !spi_busy_i && !spi_rdy_q;
        push_ok = push && ((lvl_q != LVL_FULL) || pop);
        ovf_d   = ovf_q || (push && !push_ok);

        wptr_d = push_ok ? wptr_q + AW'(1) : wptr_q;
        rptr_d = pop ? rptr_q + AW'(1) : rptr_q;
        lvl_d  = lvl_q;
        if (push_ok && !pop) begin
            lvl_d = lvl_q + LVL_W'(1);
        end else if (pop && !push_ok) begin
            lvl_d = lvl_q - LVL_W'(1);
        end

        spi_rdy_d = pop;
        spi_px_d  = pop ? mem_q[rptr_q] : spi_px_q;
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            src_q      <= 1'b0;
            ch_q       <= '0;
            pend_q     <= 1'b0;
            ch_px_q    <= '0;
            ch_rdy_q   <= '0;
            gcfg_q     <= '0;
            gcfg_rdy_q <= 1'b0;
            spi_px_q   <= '0;
            spi_rdy_q  <= 1'b0;
            infl_q     <= '0;
            lvl_q      <= '0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            ovf_q      <= 1'b0;
        end else begin
            src_q      <= src_d;
            ch_q       <= ch_d;
            pend_q     <= pend_d;
            ch_px_q    <= ch_px_d;
            ch_rdy_q   <= ch_rdy_d;
            gcfg_q     <= gcfg_d;
            gcfg_rdy_q <= gcfg_rdy_d;
            spi_px_q   <= spi_px_d;
            spi_rdy_q  <= spi_rdy_d;
            infl_q     <= infl_d;
            lvl_q      <= lvl_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            ovf_q      <= ovf_d;
        end
    end

    // FIFO storage; contents are don't-care until pointers cover them
    always_ff @(posedge clk_i) begin
        if (!reset_i && push_ok) begin
            mem_q[wptr_q] <= push_px;
        end
    end

    assign spi_px_o      = spi_px_q;
    assign spi_px_rdy_o  = spi_rdy_q;
    assign gen_cfg_o     = gcfg_q;
    assign gen_cfg_rdy_o = gcfg_rdy_q;
    assign ch_px_o       = ch_px_q;
    assign ch_px_rdy_o   = ch_rdy_q;
    assign active_src_o  = src_q;
    assign active_ch_o   = ch_q;
    assign cfg_pending_o = pend_q;
    assign fifo_level_o  = lvl_q;
    assign overflow_o    = ovf_q;

endmodule

// File: tb/tb_px_stream_router.sv
// Directed bench for px_stream_router: vector table plus
// hand-written reset and out-of-range selection sequences.
module tb_px_stream_router;

    logic        clk = 1'b0;
    logic        reset_i;
    logic        src_sel_i;
    logic [1:0]  ch_sel_i;
    logic [23:0] spi_px_i;
    logic        spi_px_rdy_i;
    logic        spi_busy_i;
    logic [23:0] spi_px_o;
    logic        spi_px_rdy_o;
    logic [23:0] gen_cfg_o;
    logic        gen_cfg_rdy_o;
    logic [23:0] gen_px_i;
    logic        gen_px_rdy_i;
    logic [23:0] gen_cfg_data_i;
    logic        gen_cfg_done_i;
    logic [23:0] ch_px_o;
    logic [3:0]  ch_px_rdy_o;
    logic [95:0] ch_px_i;
    logic [3:0]  ch_px_rdy_i;
    logic        active_src_o;
    logic [1:0]  active_ch_o;
    logic        cfg_pending_o;
    logic [2:0]  fifo_level_o;
    logic        overflow_o;

    logic [1:0]  sel2;
    logic [23:0] d2_spi_px, d2_gcfg, d2_chpx;
    logic        d2_spi_rdy, d2_grdy, d2_src, d2_pend, d2_ovf;
    logic [2:0]  d2_chrdy, d2_lvl;
    logic [1:0]  d2_ch;

    int n_vec = 0;
    int n_bad = 0;
    int cur = 0;

    always #5 clk = ~clk;

    px_stream_router #(.PIXEL_BITS(24), .NUM_CH(4), .FIFO_DEPTH(4)) dut (
        .clk_i(clk), .reset_i(reset_i),
        .src_sel_i(src_sel_i), .ch_sel_i(ch_sel_i),
        .spi_px_i(spi_px_i), .spi_px_rdy_i(spi_px_rdy_i),
        .spi_busy_i(spi_busy_i),
        .spi_px_o(spi_px_o), .spi_px_rdy_o(spi_px_rdy_o),
        .gen_cfg_o(gen_cfg_o), .gen_cfg_rdy_o(gen_cfg_rdy_o),
        .gen_px_i(gen_px_i), .gen_px_rdy_i(gen_px_rdy_i),
        .gen_cfg_data_i(gen_cfg_data_i), .gen_cfg_done_i(gen_cfg_done_i),
        .ch_px_o(ch_px_o), .ch_px_rdy_o(ch_px_rdy_o),
        .ch_px_i(ch_px_i), .ch_px_rdy_i(ch_px_rdy_i),
        .active_src_o(active_src_o), .active_ch_o(active_ch_o),
        .cfg_pending_o(cfg_pending_o), .fifo_level_o(fifo_level_o),
        .overflow_o(overflow_o)
    );

    px_stream_router #(.PIXEL_BITS(24), .NUM_CH(3), .FIFO_DEPTH(4)) dut3 (
        .clk_i(clk), .reset_i(reset_i),
        .src_sel_i(1'b0), .ch_sel_i(sel2),
        .spi_px_i(24'h0), .spi_px_rdy_i(1'b0),
        .spi_busy_i(1'b0),
        .spi_px_o(d2_spi_px), .spi_px_rdy_o(d2_spi_rdy),
        .gen_cfg_o(d2_gcfg), .gen_cfg_rdy_o(d2_grdy),
        .gen_px_i(24'h0), .gen_px_rdy_i(1'b0),
        .gen_cfg_data_i(24'h0), .gen_cfg_done_i(1'b0),
        .ch_px_o(d2_chpx), .ch_px_rdy_o(d2_chrdy),
        .ch_px_i(72'h0), .ch_px_rdy_i(3'b000),
        .active_src_o(d2_src), .active_ch_o(d2_ch),
        .cfg_pending_o(d2_pend), .fifo_level_o(d2_lvl),
        .overflow_o(d2_ovf)
    );

    typedef struct {
        logic        s;
        logic [1:0]  sel;
        logic        sr;
        logic [23:0] spx;
        logic        b;
        logic        gr;
        logic [23:0] gpx;
        logic        gd;
        logic [23:0] gdat;
        logic [3:0]  cr;
        logic [23:0] cd;
        logic [23:0] e_chpx;
        logic [3:0]  e_chr;
        logic [23:0] e_spx;
        logic        e_sr;
        logic [23:0] e_gc;
        logic        e_gr;
        logic        e_as;
        logic [1:0]  e_ach;
        logic        e_pd;
        logic [2:0]  e_lvl;
        logic        e_ov;
    } vec_t;

    vec_t tv[$];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s step %0d: got %h want %h", nm, cur, act, exp);
        end
    endtask

    task automatic clr_in();
        src_sel_i = 0; ch_sel_i = 0; spi_px_i = 0; spi_px_rdy_i = 0;
        spi_busy_i = 0; gen_px_i = 0; gen_px_rdy_i = 0;
        gen_cfg_data_i = 0; gen_cfg_done_i = 0;
        ch_px_i = '0; ch_px_rdy_i = 0;
    endtask

    // Slice k carries cd XOR (k<<20), so each channel sees distinct data
    task automatic drive(input vec_t v);
        src_sel_i = v.s; ch_sel_i = v.sel;
        spi_px_i = v.spx; spi_px_rdy_i = v.sr; spi_busy_i = v.b;
        gen_px_i = v.gpx; gen_px_rdy_i = v.gr;
        gen_cfg_data_i = v.gdat; gen_cfg_done_i = v.gd;
        ch_px_rdy_i = v.cr;
        for (int k = 0; k < 4; k++) begin
            ch_px_i[k*24 +: 24] = v.cd ^ (24'(k) << 20);
        end
    endtask

    task automatic chk_all(input vec_t v);
        chk("ch_px_o", 32'(ch_px_o), 32'(v.e_chpx));
        chk("ch_px_rdy_o", 32'(ch_px_rdy_o), 32'(v.e_chr));
        chk("spi_px_o", 32'(spi_px_o), 32'(v.e_spx));
        chk("spi_px_rdy_o", 32'(spi_px_rdy_o), 32'(v.e_sr));
        chk("gen_cfg_o", 32'(gen_cfg_o), 32'(v.e_gc));
        chk("gen_cfg_rdy_o", 32'(gen_cfg_rdy_o), 32'(v.e_gr));
        chk("active_src_o", 32'(active_src_o), 32'(v.e_as));
        chk("active_ch_o", 32'(active_ch_o), 32'(v.e_ach));
        chk("cfg_pending_o", 32'(cfg_pending_o), 32'(v.e_pd));
        chk("fifo_level_o", 32'(fifo_level_o), 32'(v.e_lvl));
        chk("overflow_o", 32'(overflow_o), 32'(v.e_ov));
    endtask

    initial begin
        // s sel sr spx b gr gpx gd gdat cr cd | chpx chr spx sr gc gr as ach pd lvl ov
        tv.push_back('{0,2,0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,2,0,0,0});
        tv.push_back('{0,2,1,'hABCDEF,0,0,0,0,0,0,0, 'hABCDEF,4,0,0,0,0,0,2,0,0,0});
        tv.push_back('{0,2,0,0,0,0,0,0,0,0,0, 'hABCDEF,0,0,0,0,0,0,2,0,0,0});
        tv.push_back('{0,2,0,0,0,0,0,0,0,4,'h323456, 'hABCDEF,0,0,0,0,0,0,2,0,1,0});
        tv.push_back('{0,2,0,0,0,0,0,0,0,0,0, 'hABCDEF,0,'h123456,1,0,0,0,2,0,0,0});
        tv.push_back('{0,2,0,0,0,0,0,0,0,0,0, 'hABCDEF,0,'h123456,0,0,0,0,2,0,0,0});
        tv.push_back('{0,2,0,0,1,0,0,0,0,4,'h200001, 'hABCDEF,0,'h123456,0,0,0,0,2,0,1,0});
        tv.push_back('{0,2,0,0,1,0,0,0,0,4,'h200002, 'hABCDEF,0,'h123456,0,0,0,0,2,0,2,0});
        tv.push_back('{0,2,0,0,1,0,0,0,0,4,'h200003, 'hABCDEF,0,'h123456,0,0,0,0,2,0,3,0});
        tv.push_back('{0,2,0,0,1,0,0,0,0,4,'h200004, 'hABCDEF,0,'h123456,0,0,0,0,2,0,4,0});
        tv.push_back('{0,2,0,0,0,0,0,0,0,4,'h200005, 'hABCDEF,0,'h000001,1,0,0,0,2,0,4,0});
        tv.push_back('{0,2,0,0,1,0,0,0,0,4,'h200006, 'hABCDEF,0,'h000001,0,0,0,0,2,0,4,1});
        tv.push_back('{0,2,0,0,0,0,0,0,0,0,0, 'hABCDEF,0,'h000002,1,0,0,0,2,0,3,1});
        tv.push_back('{0,2,0,0,0,0,0,0,0,0,0, 'hABCDEF,0,'h000002,0,0,0,0,2,0,3,1});
        tv.push_back('{0,2,0,0,0,0,0,0,0,0,0, 'hABCDEF,0,'h000003,1,0,0,0,2,0,2,1});
        tv.push_back('{0,2,0,0,0,0,0,0,0,0,0, 'hABCDEF,0,'h000003,0,0,0,0,2,0,2,1});
        tv.push_back('{0,2,0,0,0,0,0,0,0,0,0, 'hABCDEF,0,'h000004,1,0,0,0,2,0,1,1});
        tv.push_back('{0,2,0,0,0,0,0,0,0,0,0, 'hABCDEF,0,'h000004,0,0,0,0,2,0,1,1});
        tv.push_back('{0,2,0,0,0,0,0,0,0,0,0, 'hABCDEF,0,'h000005,1,0,0,0,2,0,0,1});
        tv.push_back('{0,2,0,0,0,0,0,0,0,0,0, 'hABCDEF,0,'h000005,0,0,0,0,2,0,0,1});
        tv.push_back('{0,2,1,'h111111,0,0,0,0,0,0,0, 'h111111,4,'h000005,0,0,0,0,2,0,0,1});
        tv.push_back('{0,1,0,0,0,0,0,0,0,0,0, 'h111111,0,'h000005,0,0,0,0,2,1,0,1});
        tv.push_back('{0,1,0,0,0,0,0,0,0,0,0, 'h111111,0,'h000005,0,0,0,0,2,1,0,1});
        tv.push_back('{0,1,0,0,0,0,0,0,0,4,'h022222, 'h111111,0,'h000005,0,0,0,0,2,1,1,1});
        tv.push_back('{0,1,0,0,0,0,0,0,0,0,0, 'h111111,0,'h222222,1,0,0,0,2,1,0,1});
        tv.push_back('{0,1,0,0,0,0,0,0,0,0,0, 'h111111,0,'h222222,0,0,0,0,2,1,0,1});
        tv.push_back('{0,1,0,0,0,0,0,0,0,0,0, 'h111111,0,'h222222,0,0,0,0,1,0,0,1});
        tv.push_back('{0,1,1,'h444444,0,0,0,0,0,0,0, 'h444444,2,'h222222,0,0,0,0,1,0,0,1});
        tv.push_back('{0,1,0,0,0,0,0,0,0,0,0, 'h444444,0,'h222222,0,0,0,0,1,0,0,1});
        tv.push_back('{0,3,0,0,0,0,0,0,0,4,'h333333, 'h444444,0,'h222222,0,0,0,0,1,1,0,1});
        tv.push_back('{0,3,0,0,0,0,0,0,0,0,0, 'h444444,0,'h222222,0,0,0,0,1,1,0,1});
        tv.push_back('{0,3,0,0,0,0,0,0,0,2,'h455555, 'h444444,0,'h222222,0,0,0,0,1,1,1,1});
        tv.push_back('{0,3,0,0,0,0,0,0,0,0,0, 'h444444,0,'h555555,1,0,0,0,1,1,0,1});
        tv.push_back('{0,3,0,0,0,0,0,0,0,0,0, 'h444444,0,'h555555,0,0,0,0,1,1,0,1});
        tv.push_back('{0,3,0,0,0,0,0,0,0,0,0, 'h444444,0,'h555555,0,0,0,0,3,0,0,1});
        tv.push_back('{1,3,0,0,0,0,0,0,0,0,0, 'h444444,0,'h555555,0,0,0,1,3,0,0,1});
        tv.push_back('{1,3,1,'h00000F,0,0,0,0,0,0,0, 'h444444,0,'h555555,0,'h00000F,1,1,3,0,0,1});
        tv.push_back('{1,3,0,0,0,0,0,1,'h0000AA,0,0, 'h444444,0,'h555555,0,'h00000F,0,1,3,0,1,1});
        tv.push_back('{1,3,0,0,0,0,0,0,0,0,0, 'h444444,0,'h0000AA,1,'h00000F,0,1,3,0,0,1});
        tv.push_back('{1,3,0,0,0,1,'h000055,0,0,0,0, 'h000055,8,'h0000AA,0,'h00000F,0,1,3,0,0,1});
        tv.push_back('{1,3,0,0,0,0,0,0,0,0,0, 'h000055,0,'h0000AA,0,'h00000F,0,1,3,0,0,1});
        tv.push_back('{1,3,0,0,0,0,0,0,0,8,'h477777, 'h000055,0,'h0000AA,0,'h00000F,0,1,3,0,0,1});
        tv.push_back('{0,0,0,0,0,0,0,0,0,0,0, 'h000055,0,'h0000AA,0,'h00000F,0,0,0,0,0,1});

        clr_in();
        sel2 = 0;
        reset_i = 1;
        step();
        step();
        cur = -1;
        chk("rst ch_px_rdy_o", 32'(ch_px_rdy_o), 0);
        chk("rst spi_px_rdy_o", 32'(spi_px_rdy_o), 0);
        chk("rst spi_px_o", 32'(spi_px_o), 0);
        chk("rst fifo_level_o", 32'(fifo_level_o), 0);
        chk("rst overflow_o", 32'(overflow_o), 0);
        chk("rst active_ch_o", 32'(active_ch_o), 0);
        chk("rst active_src_o", 32'(active_src_o), 0);
        reset_i = 0;

        for (int i = 0; i < tv.size(); i++) begin
            cur = i;
            drive(tv[i]);
            step();
            chk_all(tv[i]);
        end

        // Reset with three words queued and a sticky overflow
        cur = 100;
        clr_in();
        ch_sel_i = 3;
        step();
        chk("pre-rst active_ch_o", 32'(active_ch_o), 3);
        spi_busy_i = 1;
        ch_px_rdy_i = 4'b1000;
        ch_px_i[72 +: 24] = 24'h0A0B0C;
        step();
        step();
        step();
        ch_px_rdy_i = 0;
        chk("pre-rst fifo_level_o", 32'(fifo_level_o), 3);
        chk("pre-rst overflow_o", 32'(overflow_o), 1);
        cur = 101;
        reset_i = 1;
        spi_busy_i = 0;
        step();
        chk("mid-rst fifo_level_o", 32'(fifo_level_o), 0);
        chk("mid-rst overflow_o", 32'(overflow_o), 0);
        chk("mid-rst active_ch_o", 32'(active_ch_o), 0);
        chk("mid-rst spi_px_rdy_o", 32'(spi_px_rdy_o), 0);
        chk("mid-rst cfg_pending_o", 32'(cfg_pending_o), 0);
        cur = 102;
        reset_i = 0;
        ch_sel_i = 0;
        step();
        chk("post-rst spi_px_rdy_o", 32'(spi_px_rdy_o), 0);
        chk("post-rst fifo_level_o", 32'(fifo_level_o), 0);
        step();
        chk("post-rst2 spi_px_rdy_o", 32'(spi_px_rdy_o), 0);

        // Out-of-range channel on a 3-channel router is never applied
        cur = 200;
        sel2 = 3;
        step();
        step();
        step();
        chk("oor cfg_pending_o", 32'(d2_pend), 1);
        chk("oor active_ch_o", 32'(d2_ch), 0);
        cur = 201;
        sel2 = 2;
        step();
        chk("inrange active_ch_o", 32'(d2_ch), 2);
        chk("inrange cfg_pending_o", 32'(d2_pend), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
